// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline-stage register with valid/ready handshake, optional skid entry, flush and kill
//
// Parameters
//   DW   : write-data width per write-back channel
//   RW   : register-index width per channel
//   NWB  : number of write-back channels (1..4)
//   SKID : 1 = head + skid entry, registered in_ready; 0 = single entry, combinational in_ready
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake
//   in_kill               : instruction travels down the pipe but writes nothing
//   in_we / in_wr / in_wd : per-channel write enable, index, data (channel k at [k*W +: W])
//   in_pc                 : debug PC
//   flush                 : synchronous clear of all held entries
//   out_valid / out_ready : downstream handshake
//   out_we / out_wr / out_wd / out_pc : head entry payload (out_we gated by out_valid)
//   occupancy             : number of held entries, 0..2
module pipe_stage_buf #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int NWB  = 1,
    parameter int SKID = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kill,
    input  logic [NWB-1:0]    in_we,
    input  logic [NWB*RW-1:0] in_wr,
    input  logic [NWB*DW-1:0] in_wd,
    input  logic [31:0]       in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NWB-1:0]    out_we,
    output logic [NWB*RW-1:0] out_wr,
    output logic [NWB*DW-1:0] out_wd,
    output logic [31:0]       out_pc,
    output logic [1:0]        occupancy
);

    // Head (H) entry
    logic              h_valid_q, h_valid_d;
    logic [NWB-1:0]    h_we_q,    h_we_d;
    logic [NWB*RW-1:0] h_wr_q,    h_wr_d;
    logic [NWB*DW-1:0] h_wd_q,    h_wd_d;
    logic [31:0]       h_pc_q,    h_pc_d;

    // Skid (S) entry; never loaded when SKID=0
    logic              s_valid_q, s_valid_d;
    logic [NWB-1:0]    s_we_q,    s_we_d;
    logic [NWB*RW-1:0] s_wr_q,    s_wr_d;
    logic [NWB*DW-1:0] s_wd_q,    s_wd_d;
    logic [31:0]       s_pc_q,    s_pc_d;

    logic           accept;
    logic           retire;
    logic           load_h;
    logic           load_s;
    logic           move_sh;
    logic [NWB-1:0] we_masked;

    // With a skid entry, in_ready depends only on a flop so the upstream
    // ready path is cut; without it, a draining head frees the slot at once.
    assign in_ready = (SKID != 0) ? ~s_valid_q : (~h_valid_q | out_ready);

    assign accept    = in_valid & in_ready & ~flush;
    assign retire    = h_valid_q & out_ready;
    assign we_masked = in_we & ~{NWB{in_kill}};

    // Input goes to H when H is free or being retired; otherwise to S.
    // accept is impossible while S is valid, so load_h never collides with move_sh.
    assign load_h  = accept & (~h_valid_q | retire);
    assign load_s  = (SKID != 0) & accept & h_valid_q & ~retire;
    assign move_sh = s_valid_q & retire & ~flush;

    always_comb begin
        h_valid_d = h_valid_q;
        h_we_d    = h_we_q;
        h_wr_d    = h_wr_q;
        h_wd_d    = h_wd_q;
        h_pc_d    = h_pc_q;
        s_valid_d = s_valid_q;
        s_we_d    = s_we_q;
        s_wr_d    = s_wr_q;
        s_wd_d    = s_wd_q;
        s_pc_d    = s_pc_q;

        if (load_h) begin
            h_valid_d = 1'b1;
            h_we_d    = we_masked;
            h_wr_d    = in_wr;
            h_wd_d    = in_wd;
            h_pc_d    = in_pc;
        end else if (move_sh) begin
            h_valid_d = 1'b1;
            h_we_d    = s_we_q;
            h_wr_d    = s_wr_q;
            h_wd_d    = s_wd_q;
            h_pc_d    = s_pc_q;
        end else if (retire) begin
            h_valid_d = 1'b0;
        end

        if (load_s) begin
            s_valid_d = 1'b1;
            s_we_d    = we_masked;
            s_wr_d    = in_wr;
            s_wd_d    = in_wd;
            s_pc_d    = in_pc;
        end else if (move_sh) begin
            s_valid_d = 1'b0;
        end

        // Flush wins over everything; data and PC are left stale on purpose.
        if (flush) begin
            h_valid_d = 1'b0;
            s_valid_d = 1'b0;
            h_we_d    = '0;
            s_we_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid_q <= 1'b0;
            h_we_q    <= '0;
            h_wr_q    <= '0;
            h_wd_q    <= '0;
            h_pc_q    <= '0;
            s_valid_q <= 1'b0;
            s_we_q    <= '0;
            s_wr_q    <= '0;
            s_wd_q    <= '0;
            s_pc_q    <= '0;
        end else begin
            h_valid_q <= h_valid_d;
            h_we_q    <= h_we_d;
            h_wr_q    <= h_wr_d;
            h_wd_q    <= h_wd_d;
            h_pc_q    <= h_pc_d;
            s_valid_q <= s_valid_d;
            s_we_q    <= s_we_d;
            s_wr_q    <= s_wr_d;
            s_wd_q    <= s_wd_d;
            s_pc_q    <= s_pc_d;
        end
    end

    assign out_valid = h_valid_q;
    assign out_we    = h_we_q & {NWB{h_valid_q}};
    assign out_wr    = h_wr_q;
    assign out_wd    = h_wd_q;
    assign out_pc    = h_pc_q;
    assign occupancy = {1'b0, h_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf (SKID=1/NWB=2 and SKID=0/NWB=1)
module tb_pipe_stage_buf;

    typedef struct packed {
        logic [1:0]  we;
        logic [9:0]  wr;
        logic [63:0] wd;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT a: SKID=1, NWB=2
    logic        a_in_valid = 0, a_in_kill = 0, a_flush = 0, a_out_ready = 0;
    logic [1:0]  a_in_we = 0;
    logic [9:0]  a_in_wr = 0;
    logic [63:0] a_in_wd = 0;
    logic [31:0] a_in_pc = 0;
    logic        a_in_ready, a_out_valid;
    logic [1:0]  a_out_we, a_occ;
    logic [9:0]  a_out_wr;
    logic [63:0] a_out_wd;
    logic [31:0] a_out_pc;

    // DUT b: SKID=0, NWB=1
    logic        b_in_valid = 0, b_in_kill = 0, b_flush = 0, b_out_ready = 0;
    logic [0:0]  b_in_we = 0;
    logic [4:0]  b_in_wr = 0;
    logic [31:0] b_in_wd = 0;
    logic [31:0] b_in_pc = 0;
    logic        b_in_ready, b_out_valid;
    logic [0:0]  b_out_we;
    logic [1:0]  b_occ;
    logic [4:0]  b_out_wr;
    logic [31:0] b_out_wd;
    logic [31:0] b_out_pc;

    pipe_stage_buf #(.DW(32), .RW(5), .NWB(2), .SKID(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_kill(a_in_kill), .in_we(a_in_we), .in_wr(a_in_wr), .in_wd(a_in_wd),
        .in_pc(a_in_pc), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_we(a_out_we), .out_wr(a_out_wr), .out_wd(a_out_wd), .out_pc(a_out_pc),
        .occupancy(a_occ)
    );

    pipe_stage_buf #(.DW(32), .RW(5), .NWB(1), .SKID(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_kill(b_in_kill), .in_we(b_in_we), .in_wr(b_in_wr), .in_wd(b_in_wd),
        .in_pc(b_in_pc), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_we(b_out_we), .out_wr(b_out_wr), .out_wd(b_out_wd), .out_pc(b_out_pc),
        .occupancy(b_occ)
    );

    int n_vec = 0;
    int n_err = 0;
    bit started = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of capacity 2 (a) or 1-with-pass-through (b).
    ent_t qa[$];
    ent_t qb[$];
    ent_t ea, eb;
    bit   acc_a, ret_a, acc_b, ret_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            acc_a = a_in_valid && (qa.size() < 2) && !a_flush;
            ret_a = (qa.size() > 0) && a_out_ready;
            ea = '{we: a_in_we & ~{2{a_in_kill}}, wr: a_in_wr, wd: a_in_wd, pc: a_in_pc};
            if (a_flush) qa.delete();
            else begin
                if (ret_a) void'(qa.pop_front());
                if (acc_a) qa.push_back(ea);
            end
            acc_b = b_in_valid && (qb.size() == 0 || b_out_ready) && !b_flush;
            ret_b = (qb.size() > 0) && b_out_ready;
            eb = '{we: {1'b0, b_in_we[0] & ~b_in_kill}, wr: {5'b0, b_in_wr},
                   wd: {32'b0, b_in_wd}, pc: b_in_pc};
            if (b_flush) qb.delete();
            else begin
                if (ret_b) void'(qb.pop_front());
                if (acc_b) qb.push_back(eb);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && started) begin
            check("a_valid", a_out_valid, qa.size() > 0);
            check("a_occ", a_occ, qa.size());
            check("a_in_ready", a_in_ready, qa.size() < 2);
            if (qa.size() > 0) begin
                check("a_we", a_out_we, qa[0].we);
                check("a_wr", a_out_wr, qa[0].wr);
                check("a_wd", a_out_wd, qa[0].wd);
                check("a_pc", a_out_pc, qa[0].pc);
            end else check("a_we_idle", a_out_we, 0);
            check("b_valid", b_out_valid, qb.size() > 0);
            check("b_occ", b_occ, qb.size());
            check("b_in_ready", b_in_ready, qb.size() == 0 || b_out_ready);
            if (qb.size() > 0) begin
                check("b_we", b_out_we, qb[0].we);
                check("b_wr", b_out_wr, qb[0].wr);
                check("b_wd", b_out_wd, qb[0].wd);
                check("b_pc", b_out_pc, qb[0].pc);
            end else check("b_we_idle", b_out_we, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] pc, input logic [1:0] we, input logic kill);
        a_in_valid = v;
        a_in_pc    = pc;
        a_in_we    = we;
        a_in_kill  = kill;
        a_in_wr    = {pc[6:2] + 5'd1, pc[6:2]};
        a_in_wd    = {~pc, pc};
    endtask

    task automatic drive_b(input logic v, input logic [31:0] pc);
        b_in_valid = v;
        b_in_pc    = pc;
        b_in_we    = 1'b1;
        b_in_wr    = pc[6:2];
        b_in_wd    = pc ^ 32'h5A5A_0000;
    endtask

    task automatic check_reset_outputs();
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_we", a_out_we, 0);
        check("rst_a_wr", a_out_wr, 0);
        check("rst_a_wd", a_out_wd, 0);
        check("rst_a_pc", a_out_pc, 0);
        check("rst_a_occ", a_occ, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_valid", b_out_valid, 0);
        check("rst_b_pc", b_out_pc, 0);
        check("rst_b_occ", b_occ, 0);
        check("rst_b_in_ready", b_in_ready, 1);
    endtask

    initial begin
        #3;
        check_reset_outputs();
        step();
        rst_n   = 1'b1;
        started = 1;

        // Streaming, SKID=1 NWB=2
        a_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            drive_a(1, 32'h100 + 32'(4 * i), 2'b11, 0);
            step();
            if (i == 0) begin
                check("lit_stream_first_pc", a_out_pc, 32'h100);
                check("lit_stream_occ", a_occ, 1);
            end
            if (i == 7) begin
                check("lit_stream_last_pc", a_out_pc, 32'h11C);
                check("lit_stream_last_we", a_out_we, 2'b11);
                check("lit_stream_last_wd", a_out_wd, {~32'h11C, 32'h11C});
            end
        end
        drive_a(0, 0, 0, 0);
        step();

        // Stall
        a_out_ready = 0;
        drive_a(1, 32'h200, 2'b11, 0);
        step();
        drive_a(1, 32'h204, 2'b11, 0);
        step();
        check("lit_stall_occ", a_occ, 2);
        check("lit_stall_in_ready", a_in_ready, 0);
        drive_a(1, 32'h208, 2'b11, 0);
        step();
        check("lit_stall_hold_pc", a_out_pc, 32'h200);
        a_out_ready = 1;
        step();
        check("lit_stall_drain1", a_out_pc, 32'h204);
        step();
        check("lit_stall_drain2", a_out_pc, 32'h208);
        drive_a(0, 0, 0, 0);
        step();

        // Kill
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_kill   = 1;
        a_in_we     = 2'b01;
        a_in_wr     = 10'd7;
        a_in_wd     = 64'h0000_0000_DEAD_BEEF;
        a_in_pc     = 32'h300;
        step();
        check("lit_kill_valid", a_out_valid, 1);
        check("lit_kill_pc", a_out_pc, 32'h300);
        check("lit_kill_we", a_out_we, 0);
        drive_a(0, 0, 0, 0);
        a_out_ready = 1;
        step();

        // Flush while FULL with a same-cycle input
        a_out_ready = 0;
        drive_a(1, 32'h400, 2'b11, 0);
        step();
        drive_a(1, 32'h404, 2'b10, 0);
        step();
        drive_a(1, 32'h408, 2'b11, 0);
        a_flush = 1;
        step();
        a_flush = 0;
        drive_a(0, 0, 0, 0);
        check("lit_flush_occ", a_occ, 0);
        check("lit_flush_valid", a_out_valid, 0);
        check("lit_flush_we", a_out_we, 0);
        check("lit_flush_in_ready", a_in_ready, 1);
        a_out_ready = 1;
        step();

        // SKID=0 streaming
        b_out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            drive_b(1, 32'h700 + 32'(4 * i));
            step();
            check("lit_b_stream_in_ready", b_in_ready, 1);
        end
        check("lit_b_stream_pc", b_out_pc, 32'h714);
        drive_b(1, 32'h718);
        b_out_ready = 0;
        #1;
        check("lit_b_stall_in_ready", b_in_ready, 0);
        step();
        check("lit_b_stall_pc", b_out_pc, 32'h714);
        b_out_ready = 1;
        #1;
        check("lit_b_release_in_ready", b_in_ready, 1);
        step();
        check("lit_b_next_pc", b_out_pc, 32'h718);
        drive_b(0, 0);
        step();

        // Reset mid-stream with occupancy 2
        a_out_ready = 0;
        drive_a(1, 32'h500, 2'b11, 0);
        step();
        drive_a(1, 32'h504, 2'b11, 0);
        step();
        check("lit_pre_rst_occ", a_occ, 2);
        drive_a(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        step();
        rst_n = 1'b1;
        a_out_ready = 1;
        drive_a(1, 32'h600, 2'b01, 0);
        step();
        check("lit_post_rst_pc", a_out_pc, 32'h600);
        check("lit_post_rst_valid", a_out_valid, 1);
        drive_a(0, 0, 0, 0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register with a valid/ready handshake, optional two-entry skid buffer, synchronous flush and per-instruction kill. It generalises the fixed MEM→WB latch to any stage boundary, including MEM→WB, EX→MEM and ID→EX. It carries NWB register-write channels plus a debug PC. The downstream stage can stall without dropping or duplicating instructions. Discarded instructions are marked by an explicit kill input instead of a PC sentinel bit.

## Interface
- DW, 32, data width of each write-back channel
- RW, 5, register-index width of each channel
- NWB, 1, number of write-back channels (1..4)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  block can accept this cycle
- in_kill  in  1  instruction is discarded; travels down the pipe but writes nothing
- in_we  in  NWB  per-channel register write enable
- in_wr  in  NWB*RW  per-channel destination index, channel k at [k*RW +: RW]
- in_wd  in  NWB*DW  per-channel write data, channel k at [k*DW +: DW]
- in_pc  in  32  debug PC of the instruction
- flush  in  1  synchronous flush of all held entries
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head this cycle
- out_we  out  NWB  head write enables, already gated by kill and out_valid
- out_wr  out  NWB*RW  head destination indices
- out_wd  out  NWB*DW  head write data
- out_pc  out  32  head debug PC
- occupancy  out  2  number of held entries, 0..2

## Operation
- Accept: in_valid & in_ready & ~flush. Retire: out_valid & out_ready.
- Stored write enables = in_we & ~{NWB{in_kill}}. A killed entry occupies a slot and appears on out_valid/out_pc with out_we = 0.
- out_we = head_we & {NWB{out_valid}}. No write enable is asserted on an invalid head.
- SKID=1: two entries, head (H) and skid (S).
  - States: EMPTY (occupancy 0), ONE (H valid), FULL (H and S valid).
  - EMPTY + accept → ONE.
  - ONE + accept + retire → ONE, H loads new data.
  - ONE + accept, no retire → FULL, new data goes to S.
  - ONE + retire, no accept → EMPTY.
  - FULL + retire → ONE, S moves to H. No accept is possible because in_ready = 0.
  - in_ready = ~S_valid, taken directly from a flop.
- SKID=0: single entry H. in_ready = ~H_valid | out_ready. Accept + retire in the same cycle replaces H. Occupancy is at most 1.
- Flush: next edge clears all valid bits and stored write enables. Any same-cycle accept is dropped and any same-cycle retire still counts downstream. Data and PC fields keep their stale values.
- Payload flops load only on accept or S→H move. They do not toggle otherwise.
- Ordering is strict FIFO. Nothing is reordered, duplicated or lost except on flush.

## Timing
- Reset (async): out_valid=0, out_we=0, out_wr=0, out_wd=0, out_pc=0, occupancy=0, in_ready=1.
- Latency: an instruction accepted at edge n is at the head with out_valid=1 after edge n. This is one cycle.
- Throughput: one instruction per cycle while out_ready=1, for both SKID settings.
- SKID=1: in_ready falls the cycle after the entry that fills S is accepted. It rises the cycle after S drains.
- Flush has priority over accept, retire bookkeeping and kill.
- Reset asserted mid-stream clears state immediately, without waiting for clk. The first accept after rst_n rises is taken on the first edge with in_valid=1.

## Test plan
- Streaming, SKID=1, NWB=2: 8 back-to-back instructions, out_ready=1, in_we=2'b11, pc 0x100..0x11C. Expect the same order, one cycle later, one per cycle, occupancy=1 throughout.
- Stall: out_ready=0 for 3 cycles while feeding pc 0x200, 0x204, 0x208. Expect occupancy 1 → 2 and in_ready=0 after the second accept. 0x208 is held upstream. Releasing out_ready gives 0x200, 0x204, 0x208 with no gaps or duplicates.
- Kill: in_kill=1 with in_we=1, wr=5'd7, wd=0xDEADBEEF, pc 0x300. Expect out_valid=1, out_pc=0x300, out_we=0.
- Flush while FULL, with in_valid=1 in the same cycle. Expect occupancy=0, out_valid=0, out_we=0 next cycle, the input instruction dropped, and in_ready=1.
- SKID=0: out_ready=1 with continuous input. Expect in_ready=1 every cycle and full throughput. With out_ready=0 and H valid, expect in_ready=0 in the same cycle.
- Reset asserted mid-stream with occupancy=2. Expect all outputs 0 and in_ready=1 without a clock edge, and normal acceptance after release.
